// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock front-panel user-interface logic.
//  - Hold-state encoding used by the per-channel button hold FSM.
//  - count_width(): bits needed to hold a counter value in 0..max_val.
package clock_ui_pkg;

   localparam logic [1:0] HOLD_RELEASED = 2'd0;
   localparam logic [1:0] HOLD_PRESSED  = 2'd1;
   localparam logic [1:0] HOLD_LONG     = 2'd2;

   // Width of a counter that must reach max_val without wrapping.
   function automatic int count_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, tick-paced debounce, press/release
// edge pulses and a hold FSM producing long-press and auto-repeat pulses.
// Ports:
//  clk        system clock
//  rst_n      asynchronous active-low reset
//  tick_fast  1-clk sample strobe, timebase for debounce and hold counting
//  in_bit     raw button level, already polarity-corrected (1 = pressed)
//  deb        debounced level
//  press      1-clk pulse the clk after deb rises
//  release_p  1-clk pulse the clk after deb falls
//  long_p     1-clk pulse when the hold reaches LONG_TICKS
//  rpt        1-clk pulse with press, with long_p, then every REPEAT_TICKS
module debounce_chan
   import clock_ui_pkg::*;
#(
   parameter int STABLE_COUNT = 10,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_fast,
   input  logic in_bit,
   output logic deb,
   output logic press,
   output logic release_p,
   output logic long_p,
   output logic rpt
);

   localparam int CW       = count_width(STABLE_COUNT);
   localparam int HMAX     = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int HW       = count_width(HMAX);
   localparam int REP_LAST_I = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

   localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_COUNT);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REP_LAST_I);

   logic          s1_reg;
   logic          s2_reg;
   logic          cand_reg;
   logic [CW-1:0] cnt_reg;
   logic          deb_reg;
   logic          deb_d_reg;
   logic [1:0]    state_reg;
   logic [HW-1:0] hcnt_reg;

   assign deb = deb_reg;

   // Synchroniser and debounce. A new candidate level restarts the count;
   // deb follows the candidate on the tick where the count reaches
   // STABLE_COUNT, so STABLE_COUNT+1 equal samples (load included) are needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg    <= 1'b0;
         s2_reg    <= 1'b0;
         cand_reg  <= 1'b0;
         cnt_reg   <= '0;
         deb_reg   <= 1'b0;
         deb_d_reg <= 1'b0;
      end else begin
         s1_reg    <= in_bit;
         s2_reg    <= s1_reg;
         deb_d_reg <= deb_reg;
         if (tick_fast) begin
            if (s2_reg != cand_reg) begin
               cand_reg <= s2_reg;
               cnt_reg  <= '0;
            end else begin
               if (cnt_reg != CNT_MAX)
                  cnt_reg <= cnt_reg + 1'b1;
               if ((cnt_reg == CNT_LAST) || (cnt_reg == CNT_MAX))
                  deb_reg <= cand_reg;
            end
         end
      end
   end

   // Edge pulses and hold FSM. Release and press are acted on at any clk;
   // hold counting only advances on ticks. A low deb always wins, so the
   // release clk never carries long_p or rpt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press     <= 1'b0;
         release_p <= 1'b0;
         long_p    <= 1'b0;
         rpt       <= 1'b0;
         state_reg <= HOLD_RELEASED;
         hcnt_reg  <= '0;
      end else begin
         press     <= deb_reg & ~deb_d_reg;
         release_p <= ~deb_reg & deb_d_reg;
         long_p    <= 1'b0;
         rpt       <= 1'b0;
         if (!deb_reg) begin
            state_reg <= HOLD_RELEASED;
            hcnt_reg  <= '0;
         end else if (!deb_d_reg) begin
            state_reg <= HOLD_PRESSED;
            hcnt_reg  <= '0;
            rpt       <= 1'b1;
         end else if (tick_fast) begin
            case (state_reg)
               HOLD_PRESSED: begin
                  if (hcnt_reg == LONG_LAST) begin
                     long_p    <= 1'b1;
                     rpt       <= 1'b1;
                     state_reg <= HOLD_LONG;
                     hcnt_reg  <= '0;
                  end else begin
                     hcnt_reg <= hcnt_reg + 1'b1;
                  end
               end
               HOLD_LONG: begin
                  // REPEAT_TICKS of zero parks the channel in LONG silently.
                  if (REPEAT_TICKS != 0) begin
                     if (hcnt_reg == REP_LAST) begin
                        rpt      <= 1'b1;
                        hcnt_reg <= '0;
                     end else begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= HOLD_RELEASED;
                  hcnt_reg  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// N-channel button conditioner for the clock front panel. Applies the
// per-channel INVERT mask (1 = active-low pad) and instantiates one
// independent debounce_chan per channel.
// Ports:
//  clk        system clock
//  rst_n      asynchronous active-low reset
//  tick_fast  1-clk sample strobe (debounce and hold timebase)
//  in_raw     N asynchronous button inputs
//  deb        N debounced levels (1 = pressed)
//  press      N press pulses
//  release_p  N release pulses
//  long_p     N long-press pulses
//  rpt        N repeat pulses
module debounce_multi #(
   parameter int           N            = 4,
   parameter int           STABLE_COUNT = 10,
   parameter int           LONG_TICKS   = 1000,
   parameter int           REPEAT_TICKS = 200,
   parameter logic [N-1:0] INVERT       = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick_fast,
   input  logic [N-1:0] in_raw,
   output logic [N-1:0] deb,
   output logic [N-1:0] press,
   output logic [N-1:0] release_p,
   output logic [N-1:0] long_p,
   output logic [N-1:0] rpt
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         debounce_chan #(
            .STABLE_COUNT (STABLE_COUNT),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
         ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_fast (tick_fast),
            .in_bit    (in_raw[gi] ^ INVERT[gi]),
            .deb       (deb[gi]),
            .press     (press[gi]),
            .release_p (release_p[gi]),
            .long_p    (long_p[gi]),
            .rpt       (rpt[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: N=2, STABLE_COUNT=3, LONG_TICKS=8,
// REPEAT_TICKS=4, tick_fast every 4th clk. A second instance with
// INVERT=2'b01 covers the active-low path.
//
// Timing reference: every stimulus change is made at a negedge "d" chosen so
// ticks fall on posedges d+3, d+7, ... Then a raw edge is synchronised by
// posedge d+2, loaded at d+3, counted at d+7/d+11, accepted into deb at d+15,
// and press/release pulses are seen at cycle d+16. Hold pulses follow the
// ticks after the press: long at the 8th tick (d+47), repeats every 4 ticks.
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_fast = 1'b0;
   logic [1:0] in_raw;
   logic [1:0] deb, press, release_p, long_p, rpt;
   logic [1:0] in_raw_inv;
   logic [1:0] deb_i, press_i, release_i, long_i, rpt_i;

   int cyc = 0;
   int cmp_count = 0;
   int fail_count = 0;
   int p0[$], p1[$], r0[$], r1[$], l0[$], l1[$], t0[$], t1[$];
   int deb0_hi = 0;
   int deb1_hi = 0;

   debounce_multi #(.N(2), .STABLE_COUNT(3), .LONG_TICKS(8), .REPEAT_TICKS(4),
                    .INVERT(2'b00)) dut (
      .clk(clk), .rst_n(rst_n), .tick_fast(tick_fast), .in_raw(in_raw),
      .deb(deb), .press(press), .release_p(release_p), .long_p(long_p), .rpt(rpt));

   debounce_multi #(.N(2), .STABLE_COUNT(3), .LONG_TICKS(8), .REPEAT_TICKS(4),
                    .INVERT(2'b01)) dut_inv (
      .clk(clk), .rst_n(rst_n), .tick_fast(tick_fast), .in_raw(in_raw_inv),
      .deb(deb_i), .press(press_i), .release_p(release_i), .long_p(long_i), .rpt(rpt_i));

   always #5 clk = ~clk;

   // Cycle counter and tick strobe; updated just after each posedge so the
   // value read at a negedge refers to the upcoming posedge.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      tick_fast = ((cyc % 4) == 0);
   end

   // Pulse recorder: cycle number of every pulse, per channel.
   always @(negedge clk) begin
      if (press[0])     p0.push_back(cyc);
      if (press[1])     p1.push_back(cyc);
      if (release_p[0]) r0.push_back(cyc);
      if (release_p[1]) r1.push_back(cyc);
      if (long_p[0])    l0.push_back(cyc);
      if (long_p[1])    l1.push_back(cyc);
      if (rpt[0])       t0.push_back(cyc);
      if (rpt[1])       t1.push_back(cyc);
      if (deb[0])       deb0_hi++;
      if (deb[1])       deb1_hi++;
   end

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   task automatic clear_log();
      p0.delete(); p1.delete(); r0.delete(); r1.delete();
      l0.delete(); l1.delete(); t0.delete(); t1.delete();
      deb0_hi = 0;
      deb1_hi = 0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at a negedge d with ticks on posedges d+3+4k.
   task automatic align(output int d);
      int n;
      n = 0;
      @(negedge clk);
      while (!tick_fast && n < 8) begin
         @(negedge clk);
         n++;
      end
      cmp_count++;
      if (!tick_fast) begin
         fail_count++;
         $display("FAIL align: no tick_fast within 8 clk");
      end
      step(2);
      d = cyc;
   endtask

   task automatic test_reset();
      int d;
      rst_n = 1'b0;
      in_raw = 2'b11;
      in_raw_inv = 2'b01;
      step(3);
      #1;
      cmp_count++;
      if ({deb, press, release_p, long_p, rpt} !== 10'd0) begin
         fail_count++;
         $display("FAIL reset_hold_outputs: got %b want 0", {deb, press, release_p, long_p, rpt});
      end
      align(d);
      clear_log();
      rst_n = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step(1);
         cmp_count++;
         if ({deb, press, release_p, long_p, rpt} !== 10'd0) begin
            fail_count++;
            $display("FAIL reset_release_clk%0d: got %b want 0", k, {deb, press, release_p, long_p, rpt});
         end
      end
      step(12);
      cmp_count++;
      if (deb !== 2'b00) begin
         fail_count++;
         $display("FAIL reset_deb_early: got %b want 00 at cycle d+14", deb);
      end
      step(1);
      cmp_count++;
      if (deb !== 2'b11) begin
         fail_count++;
         $display("FAIL reset_deb_rise: got %b want 11 at cycle d+15", deb);
      end
      step(5);
      cmp_count++;
      if (p0.size() != 1 || p0[0] != d + 16 || p1.size() != 1 || p1[0] != d + 16) begin
         fail_count++;
         $display("FAIL reset_press: got n0=%0d at %0d n1=%0d at %0d want one each at %0d",
                  p0.size(), first_of(p0), p1.size(), first_of(p1), d + 16);
      end
      cmp_count++;
      if (first_of(t0) != d + 16 || first_of(t1) != d + 16) begin
         fail_count++;
         $display("FAIL reset_rpt_with_press: got %0d/%0d want %0d", first_of(t0), first_of(t1), d + 16);
      end
      cmp_count++;
      if (deb_i !== 2'b00) begin
         fail_count++;
         $display("FAIL invert_idle: got %b want 00", deb_i);
      end
      in_raw = 2'b00;
      step(60);
      cmp_count++;
      if (deb !== 2'b00) begin
         fail_count++;
         $display("FAIL reset_cleanup_deb: got %b want 00", deb);
      end
   endtask

   task automatic test_glitch();
      int d;
      align(d);
      clear_log();
      in_raw[0] = 1'b1;
      step(8);
      in_raw[0] = 1'b0;
      step(40);
      cmp_count++;
      if (p0.size() != 0 || deb0_hi != 0) begin
         fail_count++;
         $display("FAIL glitch: got press0 n=%0d deb0 high %0d clk want 0/0", p0.size(), deb0_hi);
      end
   endtask

   task automatic test_clean_press_release();
      int d;
      align(d);
      clear_log();
      in_raw[0] = 1'b1;
      step(80);
      in_raw[0] = 1'b0;
      step(40);
      cmp_count++;
      if (p0.size() != 1 || p0[0] != d + 16) begin
         fail_count++;
         $display("FAIL clean_press: got n=%0d at %0d want 1 at %0d", p0.size(), first_of(p0), d + 16);
      end
      cmp_count++;
      if (r0.size() != 1 || r0[0] != d + 96) begin
         fail_count++;
         $display("FAIL clean_release: got n=%0d at %0d want 1 at %0d", r0.size(), first_of(r0), d + 96);
      end
      cmp_count++;
      if (deb0_hi != 80) begin
         fail_count++;
         $display("FAIL clean_deb_width: got %0d clk want 80", deb0_hi);
      end
   endtask

   task automatic test_long_repeat();
      int d;
      // Press at d+16, long at d+47, repeats every 16 clk while deb stays
      // high (deb falls at d+135), release at d+136.
      int exp_rpt[7] = '{16, 47, 63, 79, 95, 111, 127};
      align(d);
      clear_log();
      in_raw[1] = 1'b1;
      step(120);
      in_raw[1] = 1'b0;
      step(60);
      cmp_count++;
      if (l1.size() != 1 || l1[0] != d + 47) begin
         fail_count++;
         $display("FAIL long_pulse: got n=%0d at %0d want 1 at %0d", l1.size(), first_of(l1), d + 47);
      end
      cmp_count++;
      if (t1.size() != 7) begin
         fail_count++;
         $display("FAIL rpt_count: got %0d want 7", t1.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            cmp_count++;
            if (t1[k] != d + exp_rpt[k]) begin
               fail_count++;
               $display("FAIL rpt_time_%0d: got %0d want %0d", k, t1[k], d + exp_rpt[k]);
            end
         end
      end
      cmp_count++;
      if (r1.size() != 1 || r1[0] != d + 136) begin
         fail_count++;
         $display("FAIL long_release: got n=%0d at %0d want 1 at %0d", r1.size(), first_of(r1), d + 136);
      end
   endtask

   task automatic test_independence();
      int d;
      align(d);
      clear_log();
      in_raw[0] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         in_raw[1] = ~in_raw[1];
         step(4);
      end
      in_raw = 2'b00;
      step(40);
      cmp_count++;
      if (p0.size() != 1 || p0[0] != d + 16 || r0.size() != 1 || r0[0] != d + 76) begin
         fail_count++;
         $display("FAIL indep_ch0: got press %0d release %0d want %0d/%0d",
                  first_of(p0), first_of(r0), d + 16, d + 76);
      end
      cmp_count++;
      if (p1.size() != 0 || r1.size() != 0 || deb1_hi != 0) begin
         fail_count++;
         $display("FAIL indep_ch1_quiet: got press n=%0d release n=%0d deb1 high %0d want 0",
                  p1.size(), r1.size(), deb1_hi);
      end
   endtask

   task automatic test_mid_hold_reset();
      int d;
      int e;
      align(d);
      clear_log();
      in_raw[1] = 1'b1;
      step(60);
      cmp_count++;
      if (l1.size() != 1) begin
         fail_count++;
         $display("FAIL midrst_reach_long: got long n=%0d want 1", l1.size());
      end
      rst_n = 1'b0;
      #1;
      cmp_count++;
      if ({deb, press, release_p, long_p, rpt} !== 10'd0) begin
         fail_count++;
         $display("FAIL midrst_async_clear: got %b want 0", {deb, press, release_p, long_p, rpt});
      end
      step(3);
      align(e);
      clear_log();
      rst_n = 1'b1;
      step(24);
      cmp_count++;
      if (r1.size() != 0 || r0.size() != 0) begin
         fail_count++;
         $display("FAIL midrst_no_release: got n=%0d/%0d want 0", r0.size(), r1.size());
      end
      cmp_count++;
      if (p1.size() != 1 || p1[0] != e + 16 || p0.size() != 0 || deb !== 2'b10) begin
         fail_count++;
         $display("FAIL midrst_repress: got press1 n=%0d at %0d deb %b want 1 at %0d deb 10",
                  p1.size(), first_of(p1), deb, e + 16);
      end
      in_raw = 2'b00;
      step(40);
   endtask

   task automatic test_invert();
      int d;
      align(d);
      in_raw_inv[0] = 1'b0;
      step(14);
      cmp_count++;
      if (deb_i !== 2'b00) begin
         fail_count++;
         $display("FAIL invert_early: got %b want 00", deb_i);
      end
      step(1);
      cmp_count++;
      if (deb_i !== 2'b01) begin
         fail_count++;
         $display("FAIL invert_press: got %b want 01", deb_i);
      end
      in_raw_inv[0] = 1'b1;
      step(40);
      cmp_count++;
      if (deb_i !== 2'b00) begin
         fail_count++;
         $display("FAIL invert_release: got %b want 00", deb_i);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_clean_press_release();
      test_long_repeat();
      test_independence();
      test_mid_hold_reset();
      test_invert();
      $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
      $finish;
   end

endmodule
